trace_capture: RTL and testbench

- Synthesizable counterpart to the simulation-only display/monitor tasks: samples a/b/c in hardware, detects value changes, and writes timestamped change records into an internal FIFO.
- A downstream reader (UART dumper, debug bus) drains the records through a show-ahead read handshake.
- Tri-state c is represented by a value bit plus an output-enable bit; c is "z" when c_oe = 0.

---
 rtl/trace_capture_if.sv | 37 +++
 rtl/trace_capture.sv | 104 ++++++++++
 tb/tb_trace_capture.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_if.sv
// Read-side bundle of trace_capture: show-ahead record port, FIFO status and overflow control.
// The capture block takes the master modport and the reader takes the slave modport.
interface trace_capture_if #(
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  rd_en;
    logic [TS_WIDTH+3:0]   rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  clear_ovf;

    modport master (
        input  rd_en,
        input  clear_ovf,
        output rd_data,
        output rd_valid,
        output empty,
        output full,
        output count,
        output overflow
    );

    modport slave (
        output rd_en,
        output clear_ovf,
        input  rd_data,
        input  rd_valid,
        input  empty,
        input  full,
        input  count,
        input  overflow
    );
endinterface

// File: rtl/trace_capture.sv
// Hardware change monitor: samples {a, b, c_oe, c & c_oe} every cycle and queues
// timestamped records of each change in a show-ahead FIFO for a downstream reader.
module trace_capture #(
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a,
    input  logic            b,
    input  logic            c,
    input  logic            c_oe,
    trace_capture_if.master rd
);
    localparam int unsigned REC_WIDTH = TS_WIDTH + 4;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic                  first_q;
    logic [3:0]            prev_q;
    logic [3:0]            sample;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [REC_WIDTH-1:0]  mem_q [DEPTH];

    logic event_hit;
    logic is_empty;
    logic is_full;
    logic pop;
    logic push;
    logic drop;

    // c only counts while it is driven, so a floating c never produces events.
    always_comb begin
        sample = {a, b, c_oe, c & c_oe};
    end

    always_comb begin
        is_empty  = (count_q == '0);
        is_full   = (count_q == FULL_COUNT);
        event_hit = first_q || (sample != prev_q);
        pop       = rd.rd_en && !is_empty;
        // A pop in the same cycle frees the slot a full FIFO needs for the new record.
        push      = event_hit && (!is_full || pop);
        drop      = event_hit && is_full && !pop;

        ts_d     = ts_q + 1'b1;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
        end else if (rd.clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q     <= '0;
            first_q  <= 1'b1;
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            first_q  <= 1'b0;
            prev_q   <= sample;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; rd_data is masked while empty so stale entries never show.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= {ts_q, sample};
        end
    end

    always_comb begin
        rd.rd_data  = is_empty ? '0 : mem_q[rd_ptr_q];
        rd.rd_valid = !is_empty;
        rd.empty    = is_empty;
        rd.full     = is_full;
        rd.count    = count_q;
        rd.overflow = ovf_q;
    end
endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: vector table, directed corner sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_trace_capture;
    localparam int unsigned TS_WIDTH   = 16;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned REC_W      = TS_WIDTH + 4;
    localparam int unsigned TS_MOD     = 1 << TS_WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c = 1'b0;
    logic c_oe = 1'b0;

    trace_capture_if #(.TS_WIDTH(TS_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) rd_if ();

    trace_capture #(
        .TS_WIDTH   (TS_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .c     (c),
        .c_oe  (c_oe),
        .rd    (rd_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: list of pending records plus a free-running timestamp.
    logic [REC_W-1:0] m_q [$];
    int unsigned      m_ts = 0;
    bit               m_first = 1'b1;
    logic [3:0]       m_prev = 4'b0;
    bit               m_ovf = 1'b0;

    typedef struct {
        bit          a, b, c, oe, rd, clr;
        int unsigned cnt;
        bit          emp, ful, ovf;
        logic [19:0] data;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit ia, ib, ic, ioe, ird, iclr, irst);
        logic [3:0] s;
        bit ev, pop, drop;
        if (irst) begin
            m_q.delete();
            m_ts    = 0;
            m_first = 1'b1;
            m_prev  = 4'b0;
            m_ovf   = 1'b0;
        end else begin
            s    = {ia, ib, ioe, ic & ioe};
            ev   = m_first || (s != m_prev);
            pop  = ird && (m_q.size() != 0);
            drop = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (ev) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_ts[TS_WIDTH-1:0], s});
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (iclr) m_ovf = 1'b0;
            m_prev  = s;
            m_first = 1'b0;
            m_ts    = (m_ts + 1) % TS_MOD;
        end
    endtask

    task automatic compare_model();
        logic [REC_W-1:0] exp_data;
        exp_data = (m_q.size() != 0) ? m_q[0] : '0;
        check("model_count", 32'(rd_if.count), 32'(m_q.size()));
        check("model_empty", 32'(rd_if.empty), 32'(m_q.size() == 0));
        check("model_full", 32'(rd_if.full), 32'(m_q.size() == DEPTH));
        check("model_valid", 32'(rd_if.rd_valid), 32'(m_q.size() != 0));
        check("model_overflow", 32'(rd_if.overflow), 32'(m_ovf));
        check("model_rd_data", 32'(rd_if.rd_data), 32'(exp_data));
    endtask

    task automatic cycle(input bit ia, ib, ic, ioe, ird, iclr, irst);
        @(negedge clk);
        a               = ia;
        b               = ib;
        c               = ic;
        c_oe            = ioe;
        rd_if.rd_en     = ird;
        rd_if.clear_ovf = iclr;
        reset           = irst;
        @(posedge clk);
        model_edge(ia, ib, ic, ioe, ird, iclr, irst);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bit av;
        int unsigned t0, tn;

        rd_if.rd_en     = 1'b0;
        rd_if.clear_ovf = 1'b0;

        //        a  b  c  oe rd clr cnt emp ful ovf data
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 20'h00000};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 20'h00000};
        vecs[2]  = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 20'h00000};
        vecs[3]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 20'h00038};
        vecs[4]  = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 20'h00038};
        vecs[5]  = '{1, 0, 1, 1, 0, 0, 2, 0, 0, 0, 20'h00038};
        vecs[6]  = '{1, 0, 0, 1, 1, 0, 2, 0, 0, 0, 20'h0005B};
        vecs[7]  = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 20'h0006A};
        vecs[8]  = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 20'h00088};
        vecs[9]  = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 20'h00000};
        vecs[10] = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 20'h000AC};

        do_reset();
        check("reset_count", 32'(rd_if.count), 32'd0);
        check("reset_empty", 32'(rd_if.empty), 32'd1);
        check("reset_full", 32'(rd_if.full), 32'd0);
        check("reset_valid", 32'(rd_if.rd_valid), 32'd0);
        check("reset_overflow", 32'(rd_if.overflow), 32'd0);
        check("reset_rd_data", 32'(rd_if.rd_data), 32'd0);

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].oe, vecs[i].rd, vecs[i].clr, 0);
            check($sformatf("vec%0d_count", i), 32'(rd_if.count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_empty", i), 32'(rd_if.empty), 32'(vecs[i].emp));
            check($sformatf("vec%0d_valid", i), 32'(rd_if.rd_valid), 32'(!vecs[i].emp));
            check($sformatf("vec%0d_full", i), 32'(rd_if.full), 32'(vecs[i].ful));
            check($sformatf("vec%0d_overflow", i), 32'(rd_if.overflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_rd_data", i), 32'(rd_if.rd_data), 32'(vecs[i].data));
        end

        // Initial record only, then a change on b at ts 100.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("init_count", 32'(rd_if.count), 32'd1);
        check("init_rec", 32'(rd_if.rd_data), 32'h00000);
        repeat (5) cycle(0, 0, 0, 0, 0, 0, 0);
        check("init_no_more", 32'(rd_if.count), 32'd1);
        while (m_ts != 100) cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("ts100_count", 32'(rd_if.count), 32'd1);
        check("ts100_rec", 32'(rd_if.rd_data), 32'h00644);
        cycle(0, 1, 0, 0, 1, 0, 0);
        check("ts100_popped", 32'(rd_if.empty), 32'd1);

        // c toggling while undriven is ignored; c_oe edges are events.
        do_reset();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, i[0], 0, 0, 0, 0);
        check("c_hiz_no_rec", 32'(rd_if.count), 32'd0);
        while (m_ts != 50) cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 0, 0);
        check("oe_rise_rec", 32'(rd_if.rd_data), 32'h00323);
        cycle(0, 0, 1, 0, 1, 0, 0);
        check("oe_fall_low2", 32'(rd_if.rd_data[1:0]), 32'd0);
        check("oe_fall_rec", 32'(rd_if.rd_data), 32'h00330);

        // Overflow, clear, write-with-pop while full, write-with-rd_en while empty.
        do_reset();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        av = 1'b0;
        t0 = m_ts;
        for (int i = 0; i < 12; i++) begin
            av = ~av;
            cycle(av, 0, 0, 0, 0, 0, 0);
        end
        check("ovf_count", 32'(rd_if.count), 32'd8);
        check("ovf_full", 32'(rd_if.full), 32'd1);
        check("ovf_set", 32'(rd_if.overflow), 32'd1);
        check("ovf_head_ts", 32'(rd_if.rd_data[REC_W-1:4]), 32'(t0));
        cycle(av, 0, 0, 0, 0, 1, 0);
        check("ovf_cleared", 32'(rd_if.overflow), 32'd0);
        av = ~av;
        tn = m_ts;
        cycle(av, 0, 0, 0, 1, 0, 0);
        check("fullpop_count", 32'(rd_if.count), 32'd8);
        check("fullpop_full", 32'(rd_if.full), 32'd1);
        check("fullpop_ovf", 32'(rd_if.overflow), 32'd0);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("consec_ts%0d", i), 32'(rd_if.rd_data[REC_W-1:4]), 32'(t0 + 1 + i));
            cycle(av, 0, 0, 0, 1, 0, 0);
        end
        check("fullpop_new_ts", 32'(rd_if.rd_data[REC_W-1:4]), 32'(tn));
        cycle(av, 0, 0, 0, 1, 0, 0);
        check("drained", 32'(rd_if.empty), 32'd1);
        av = ~av;
        cycle(av, 0, 0, 0, 1, 0, 0);
        check("empty_rd_event", 32'(rd_if.count), 32'd1);

        // Reset mid-traffic, then timestamp wrap.
        do_reset();
        av = 1'b0;
        cycle(av, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            av = ~av;
            cycle(av, 0, 0, 0, 0, 0, 0);
        end
        check("pre_reset_count", 32'(rd_if.count), 32'd5);
        cycle(~av, 0, 0, 0, 1, 0, 1);
        check("mid_reset_count", 32'(rd_if.count), 32'd0);
        check("mid_reset_empty", 32'(rd_if.empty), 32'd1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("post_reset_rec", 32'(rd_if.rd_data), 32'h00008);
        while (m_ts != TS_MOD - 1) cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("ts_max_rec", 32'(rd_if.rd_data), 32'hFFFF0);
        cycle(0, 1, 0, 0, 1, 0, 0);
        check("ts_wrap_count", 32'(rd_if.count), 32'd1);
        check("ts_wrap_rec", 32'(rd_if.rd_data), 32'h00004);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 5) == 0) ? ~a : a,
                  ($urandom_range(0, 5) == 0) ? ~b : b,
                  ($urandom_range(0, 2) == 0) ? ~c : c,
                  ($urandom_range(0, 7) == 0) ? ~c_oe : c_oe,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
